// File: rtl/event_latch_arb8_if.sv
// Event-latch arbiter bus: raw event lines in, sticky pending vector and grant handshake out.
// The mask member exists only when EVENT_MASK_EN is defined.
interface event_latch_arb8_if #(
    parameter int WIDTH = 8
);
    localparam int IW = $clog2(WIDTH);

    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] pending;
    logic             any;
    logic             grant_valid;
    logic [IW-1:0]    grant_idx;
    logic             grant_ack;
`ifdef EVENT_MASK_EN
    logic [WIDTH-1:0] mask;
`endif

    // master: event source / grant consumer; slave: the arbiter block
    modport master (
        output in, grant_ack,
`ifdef EVENT_MASK_EN
        output mask,
`endif
        input  pending, any, grant_valid, grant_idx
    );

    modport slave (
        input  in, grant_ack,
`ifdef EVENT_MASK_EN
        input  mask,
`endif
        output pending, any, grant_valid, grant_idx
    );
endinterface

// File: rtl/event_latch_arb8.sv
// Sticky event latch with round-robin valid/ack serialisation of pending events.
// Optional EVENT_MASK_EN adds a mask that hides latched bits from any/arbitration.

module event_latch_arb8_lane #(
    parameter int EDGE = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic ev,
    input  logic clr,
    output logic pend
);
    logic ev_q;
    logic s;

    assign s = (EDGE != 0) ? (ev & ~ev_q) : ev;

    // set term is OR'd in after the clear so a same-cycle set wins
    always_ff @(posedge clk) begin
        if (reset) begin
            ev_q <= 1'b0;
            pend <= 1'b0;
        end else begin
            ev_q <= ev;
            pend <= (pend & ~clr) | s;
        end
    end
endmodule

module event_latch_arb8 #(
    parameter int WIDTH = 8,
    parameter int EDGE  = 0
) (
    input logic              clk,
    input logic              reset,
    event_latch_arb8_if.slave bus
);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] elig;
    logic [WIDTH-1:0] clr;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    gidx;
    logic [IW-1:0]    pick;
    logic [IW-1:0]    idx;
    logic [IW:0]      sum;
    logic             gvld;
    logic             found;

    assign ev = bus.in;

    event_latch_arb8_lane #(.EDGE(EDGE)) u_lane [WIDTH-1:0] (
        .clk   (clk),
        .reset (reset),
        .ev    (ev),
        .clr   (clr),
        .pend  (pending)
    );

`ifdef EVENT_MASK_EN
    assign elig = pending & ~bus.mask;
`else
    assign elig = pending;
`endif

    always_comb begin
        clr = '0;
        if (state == GRANT && bus.grant_ack)
            clr[gidx] = 1'b1;
    end

    // first eligible bit scanning ptr, ptr+1, ... modulo WIDTH
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < WIDTH; k++) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(WIDTH))
                sum = sum - (IW+1)'(WIDTH);
            idx = sum[IW-1:0];
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            gvld  <= 1'b0;
            gidx  <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gidx  <= pick;
                        gvld  <= 1'b1;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (bus.grant_ack) begin
                        gvld  <= 1'b0;
                        ptr   <= (gidx == IW'(WIDTH-1)) ? '0 : gidx + IW'(1);
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pending     = pending;
    assign bus.any         = |elig;
    assign bus.grant_valid = gvld;
    assign bus.grant_idx   = gidx;
endmodule

// File: tb/tb_event_latch_arb8.sv
// Self-checking bench: vector table for capture/drain, scoreboard queue of expected grant
// indices, plus hand sequences for wrap, set/clear collision, reset mid-grant, edge and mask.
module tb_event_latch_arb8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    event_latch_arb8_if #(.WIDTH(8)) b0 ();
    event_latch_arb8_if #(.WIDTH(8)) b1 ();

    event_latch_arb8 #(.WIDTH(8), .EDGE(0)) dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
    event_latch_arb8 #(.WIDTH(8), .EDGE(1)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));

    typedef struct {
        logic [7:0] in_v;
        int         hold;
        logic [7:0] exp_pend;
        logic       exp_any;
    } vec_t;

    vec_t       vt [6];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         exp_q [$];
    logic [2:0] mptr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        b0.in = '0; b0.grant_ack = 1'b0;
        b1.in = '0; b1.grant_ack = 1'b0;
`ifdef EVENT_MASK_EN
        b0.mask = '0; b1.mask = '0;
`endif
        cyc(2);
        reset = 1'b0;
        mptr = '0;
    endtask

    // reference order: set bits visited from the model pointer upward, modulo 8
    task automatic push_order(input logic [7:0] p);
        for (int k = 0; k < 8; k++) begin
            logic [2:0] j;
            j = mptr + 3'(k);
            if (p[j]) exp_q.push_back(int'(j));
        end
    endtask

    task automatic wait_gv(input string name, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (b0.grant_valid) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        n_tests++;
        n_fail++;
        $display("FAIL %s: grant_valid never rose within 20 cycles", name);
    endtask

    task automatic drain(input string name);
        while (exp_q.size() > 0) begin
            bit ok;
            int e;
            wait_gv(name, ok);
            if (!ok) begin
                exp_q.delete();
                return;
            end
            e = exp_q.pop_front();
            chk({name, " idx"}, 32'(b0.grant_idx), 32'(e));
            cyc(1);
            chk({name, " hold valid"}, 32'(b0.grant_valid), 32'd1);
            chk({name, " hold idx"}, 32'(b0.grant_idx), 32'(e));
            b0.grant_ack = 1'b1;
            mptr = 3'(e + 1);
            cyc(1);
            b0.grant_ack = 1'b0;
            chk({name, " idle gap"}, 32'(b0.grant_valid), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        vt[0] = '{8'h00, 4, 8'h00, 1'b0};
        vt[1] = '{8'hAA, 1, 8'hAA, 1'b1};
        vt[2] = '{8'h81, 1, 8'h81, 1'b1};
        vt[3] = '{8'h01, 2, 8'h01, 1'b1};
        vt[4] = '{8'hFF, 1, 8'hFF, 1'b1};
        vt[5] = '{8'h3C, 3, 8'h3C, 1'b1};

        do_reset();
        chk("rst pending", 32'(b0.pending), 32'h0);
        chk("rst any", 32'(b0.any), 32'h0);
        chk("rst valid", 32'(b0.grant_valid), 32'h0);
        chk("rst idx", 32'(b0.grant_idx), 32'h0);
        chk("rst edge pending", 32'(b1.pending), 32'h0);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            b0.in = vt[i].in_v;
            cyc(vt[i].hold);
            b0.in = '0;
            chk($sformatf("vec%0d pending", i), 32'(b0.pending), 32'(vt[i].exp_pend));
            chk($sformatf("vec%0d any", i), 32'(b0.any), 32'(vt[i].exp_any));
            push_order(vt[i].exp_pend);
            drain($sformatf("vec%0d", i));
            chk($sformatf("vec%0d drained", i), 32'(b0.pending), 32'h0);
            chk($sformatf("vec%0d any off", i), 32'(b0.any), 32'h0);
        end

        // all lines held: round-robin walks 0..7 and wraps back to 0
        do_reset();
        b0.in = 8'hFF;
        cyc(1);
        for (int k = 0; k < 9; k++) exp_q.push_back(k % 8);
        drain("wrap");
        chk("wrap pending", 32'(b0.pending), 32'hFF);
        b0.in = '0;
        push_order(8'hFF);
        drain("wrap tail");
        chk("wrap tail pending", 32'(b0.pending), 32'h0);

        // set and ack-clear of bit 0 in the same cycle
        do_reset();
        b0.in = 8'h01;
        cyc(1);
        b0.in = '0;
        wait_gv("collide", ok);
        chk("collide idx", 32'(b0.grant_idx), 32'h0);
        b0.grant_ack = 1'b1;
        b0.in = 8'h01;
        cyc(1);
        b0.grant_ack = 1'b0;
        b0.in = '0;
        chk("collide pending", 32'(b0.pending), 32'h01);
        chk("collide valid", 32'(b0.grant_valid), 32'h0);
        mptr = 3'd1;
        push_order(8'h01);
        drain("collide regrant");
        chk("collide drained", 32'(b0.pending), 32'h0);

        // reset mid-grant, with a simultaneous ack
        do_reset();
        b0.in = 8'h81;
        cyc(1);
        b0.in = '0;
        wait_gv("midrst", ok);
        chk("midrst pending", 32'(b0.pending), 32'h81);
        reset = 1'b1;
        b0.grant_ack = 1'b1;
        cyc(1);
        reset = 1'b0;
        b0.grant_ack = 1'b0;
        chk("midrst pending clr", 32'(b0.pending), 32'h0);
        chk("midrst any", 32'(b0.any), 32'h0);
        chk("midrst valid", 32'(b0.grant_valid), 32'h0);
        chk("midrst idx", 32'(b0.grant_idx), 32'h0);
        mptr = '0;
        b0.in = 8'h81;
        cyc(1);
        b0.in = '0;
        push_order(8'h81);
        drain("midrst after");

        // ack with no grant outstanding is ignored
        do_reset();
        b0.grant_ack = 1'b1;
        b0.in = 8'h04;
        cyc(1);
        chk("stray ack pending", 32'(b0.pending), 32'h04);
        chk("stray ack valid", 32'(b0.grant_valid), 32'h0);
        b0.grant_ack = 1'b0;
        b0.in = '0;
        push_order(8'h04);
        drain("stray ack");

        // rising-edge capture: a held line produces a single grant
        do_reset();
        b1.in = 8'h01;
        cyc(1);
        chk("edge pending", 32'(b1.pending), 32'h01);
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            if (b1.grant_valid) ok = 1'b1;
            else cyc(1);
        end
        chk("edge grant seen", 32'(ok), 32'd1);
        chk("edge idx", 32'(b1.grant_idx), 32'h0);
        b1.grant_ack = 1'b1;
        cyc(1);
        b1.grant_ack = 1'b0;
        cyc(4);
        chk("edge held pending", 32'(b1.pending), 32'h0);
        chk("edge held valid", 32'(b1.grant_valid), 32'h0);
        b1.in = '0;
        cyc(1);
        b1.in = 8'h01;
        cyc(1);
        chk("edge rearm", 32'(b1.pending), 32'h01);

`ifdef EVENT_MASK_EN
        do_reset();
        b0.mask = 8'h0F;
        b0.in = 8'hF0;
        cyc(1);
        b0.in = '0;
        chk("mask0F pending", 32'(b0.pending), 32'hF0);
        chk("mask0F any", 32'(b0.any), 32'h1);
        push_order(8'hF0);
        drain("mask0F");

        do_reset();
        b0.mask = 8'hF0;
        b0.in = 8'hF0;
        cyc(1);
        b0.in = '0;
        chk("maskF0 pending", 32'(b0.pending), 32'hF0);
        chk("maskF0 any", 32'(b0.any), 32'h0);
        cyc(5);
        chk("maskF0 no grant", 32'(b0.grant_valid), 32'h0);
        b0.mask = '0;
        push_order(8'hF0);
        drain("maskF0 unmask");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
